// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the 5-stage pipeline. It detects load-use hazards
// and taken branches, and owns the data-memory request/ready handshake with a
// wait-timeout watchdog and a saturating stall-cycle counter.
module pipeline_hazard_controller #(
   parameter int unsigned TIMEOUT = 64,
   parameter int unsigned CNT_W   = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [4:0]       rs1_d,
   input  logic [4:0]       rs2_d,
   input  logic [4:0]       rd_e,
   input  logic             load_e,
   input  logic             pc_src_e,
   input  logic             mem_access_m,
   input  logic             mem_ready,
   output logic             mem_req,
   output logic             stall_f,
   output logic             stall_d,
   output logic             stall_e,
   output logic             stall_m,
   output logic             flush_d,
   output logic             flush_e,
   output logic             flush_w,
   output logic             mem_err,
   output logic [CNT_W-1:0] stall_cnt
);

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      ERROR    = 2'd2
   } state_t;

   localparam logic [7:0] TIMEOUT_V = 8'(TIMEOUT);

   state_t     state, state_next;
   logic [7:0] wait_cnt, wait_next;
   logic       req_raw;
   logic       mem_stall;
   logic       lw_stall;

   // Memory handshake, hazard detection and the next-state/wait-counter logic
   always_comb begin
      state_next = state;
      wait_next  = wait_cnt;
      req_raw    = 1'b0;
      case (state)
         RUN: begin
            req_raw = mem_access_m;
            if (mem_access_m && !mem_ready) begin
               state_next = MEM_WAIT;
               wait_next  = 8'd1;
            end
         end
         MEM_WAIT: begin
            req_raw = 1'b1;
            if (mem_ready) begin
               state_next = RUN;
               wait_next  = '0;
            end else if (wait_cnt == TIMEOUT_V) begin
               state_next = ERROR;
               wait_next  = '0;
            end else begin
               wait_next = wait_cnt + 8'd1;
            end
         end
         ERROR: begin
            req_raw = 1'b0;
         end
         default: begin
            state_next = RUN;
            wait_next  = '0;
         end
      endcase

      mem_stall = (req_raw && !mem_ready) || (state == ERROR);
      lw_stall  = load_e && (rd_e != 5'd0) &&
                  ((rd_e == rs1_d) || (rd_e == rs2_d));
   end

   // Prioritised stall/flush decode; everything is held low while in reset
   always_comb begin
      mem_req = 1'b0;
      stall_f = 1'b0;
      stall_d = 1'b0;
      stall_e = 1'b0;
      stall_m = 1'b0;
      flush_d = 1'b0;
      flush_e = 1'b0;
      flush_w = 1'b0;
      if (reset) begin
         mem_req = req_raw;
         if (mem_stall) begin
            // E keeps its branch/load, so no flush while memory stalls
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_e = 1'b1;
            stall_m = 1'b1;
            flush_w = 1'b1;
         end else if (lw_stall) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            flush_e = 1'b1;
            flush_d = pc_src_e;
         end else if (pc_src_e) begin
            flush_d = 1'b1;
            flush_e = 1'b1;
         end
      end
   end

   // State, wait counter, sticky error flag and saturating stall counter
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= RUN;
         wait_cnt  <= '0;
         mem_err   <= 1'b0;
         stall_cnt <= '0;
      end else begin
         state    <= state_next;
         wait_cnt <= wait_next;
         mem_err  <= mem_err || (state_next == ERROR);
         if (stall_f && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed bench for pipeline_hazard_controller with hand-computed vectors.
// The stall/flush outputs are packed as
// {mem_req, stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w}.
module tb_pipeline_hazard_controller;

   localparam int unsigned CNT_W = 4;

   logic             clk = 1'b0;
   logic             reset;
   logic [4:0]       rs1_d, rs2_d, rd_e;
   logic             load_e, pc_src_e, mem_access_m, mem_ready;
   logic             mem_req, stall_f, stall_d, stall_e, stall_m;
   logic             flush_d, flush_e, flush_w, mem_err;
   logic [CNT_W-1:0] stall_cnt;
   logic [7:0]       outs;

   int unsigned checks = 0;
   int unsigned errors = 0;

   pipeline_hazard_controller #(
      .TIMEOUT (4),
      .CNT_W   (CNT_W)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .rs1_d        (rs1_d),
      .rs2_d        (rs2_d),
      .rd_e         (rd_e),
      .load_e       (load_e),
      .pc_src_e     (pc_src_e),
      .mem_access_m (mem_access_m),
      .mem_ready    (mem_ready),
      .mem_req      (mem_req),
      .stall_f      (stall_f),
      .stall_d      (stall_d),
      .stall_e      (stall_e),
      .stall_m      (stall_m),
      .flush_d      (flush_d),
      .flush_e      (flush_e),
      .flush_w      (flush_w),
      .mem_err      (mem_err),
      .stall_cnt    (stall_cnt)
   );

   assign outs = {mem_req, stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w};

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic ld, input logic [4:0] rd, input logic [4:0] r1,
                        input logic [4:0] r2, input logic br, input logic acc, input logic rdy);
      load_e       = ld;
      rd_e         = rd;
      rs1_d        = r1;
      rs2_d        = r2;
      pc_src_e     = br;
      mem_access_m = acc;
      mem_ready    = rdy;
      #1;
   endtask

   initial begin
      reset = 1'b0;
      // Reset forces outputs low even with every hazard input active
      drive(1'b1, 5'd5, 5'd0, 5'd5, 1'b1, 1'b1, 1'b0);
      check("reset_outs", 32'(outs), 32'h00);
      check("reset_err", 32'(mem_err), 32'd0);
      check("reset_cnt", 32'(stall_cnt), 32'd0);
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      tick();
      reset = 1'b1;

      // Load-use on rs2
      drive(1'b1, 5'd5, 5'd3, 5'd5, 1'b0, 1'b0, 1'b0);
      check("lw_use", 32'(outs), 32'b0110_0010);
      tick();
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      check("lw_one_cycle", 32'(outs), 32'h00);
      check("lw_cnt", 32'(stall_cnt), 32'd1);

      // Load into x0 never stalls
      drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      check("lw_x0", 32'(outs), 32'h00);
      tick();
      check("lw_x0_cnt", 32'(stall_cnt), 32'd1);

      // Branch alone, then branch with load-use on rs1
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
      check("branch", 32'(outs), 32'b0000_0110);
      drive(1'b1, 5'd7, 5'd7, 5'd2, 1'b1, 1'b0, 1'b0);
      check("branch_lw", 32'(outs), 32'b0110_0110);
      tick();
      check("branch_lw_cnt", 32'(stall_cnt), 32'd2);

      // Memory wait: three not-ready cycles, branch pending in E from the second
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
      check("mw_run_stall", 32'(outs), 32'b1111_1001);
      tick();
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0);
      check("mw_wait1_prio", 32'(outs), 32'b1111_1001);
      tick();
      check("mw_wait2_prio", 32'(outs), 32'b1111_1001);
      tick();
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1);
      check("mw_ready_flush", 32'(outs), 32'b1000_0110);
      tick();
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      check("mw_back_run", 32'(outs), 32'h00);
      check("mw_cnt", 32'(stall_cnt), 32'd5);

      // Zero-wait access stays in RUN
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1);
      check("zero_wait", 32'(outs), 32'b1000_0000);
      tick();
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      check("zero_wait_run", 32'(outs), 32'h00);
      check("zero_wait_cnt", 32'(stall_cnt), 32'd5);

      // Reset asserted mid-MEM_WAIT acts immediately
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
      tick();
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      check("mw_req_held", 32'(outs), 32'b1111_1001);
      reset = 1'b0;
      #1;
      check("mw_reset_outs", 32'(outs), 32'h00);
      check("mw_reset_cnt", 32'(stall_cnt), 32'd0);
      tick();
      reset = 1'b1;
      #1;
      check("mw_reset_run", 32'(outs), 32'h00);

      // Ready in the last allowed wait cycle returns to RUN, not ERROR
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) tick();
      check("to_edge_stall", 32'(outs), 32'b1111_1001);
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1);
      check("to_edge_ready", 32'(outs), 32'b1000_0000);
      tick();
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      check("to_edge_run", 32'(outs), 32'h00);
      check("to_edge_err", 32'(mem_err), 32'd0);
      check("to_edge_cnt", 32'(stall_cnt), 32'd4);

      // Timeout: one RUN stall cycle plus four wait cycles, then ERROR
      reset = 1'b0;
      #1;
      reset = 1'b1;
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) tick();
      check("to_last_wait", 32'(outs), 32'b1111_1001);
      check("to_last_err", 32'(mem_err), 32'd0);
      tick();
      check("to_error_outs", 32'(outs), 32'b0111_1001);
      check("to_error_err", 32'(mem_err), 32'd1);
      check("to_error_cnt", 32'(stall_cnt), 32'd5);

      // ERROR ignores ready and branches; counter saturates
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1);
      check("err_hold_outs", 32'(outs), 32'b0111_1001);
      for (int i = 0; i < 12; i++) tick();
      check("err_sticky_outs", 32'(outs), 32'b0111_1001);
      check("err_sticky", 32'(mem_err), 32'd1);
      check("cnt_saturate", 32'(stall_cnt), 32'd15);

      // Reset is the only way out of ERROR
      reset = 1'b0;
      #1;
      check("err_reset_outs", 32'(outs), 32'h00);
      check("err_reset_err", 32'(mem_err), 32'd0);
      check("err_reset_cnt", 32'(stall_cnt), 32'd0);
      tick();
      reset = 1'b1;
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
      check("err_reset_run", 32'(outs), 32'b0000_0110);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pipeline_hazard_controller.md
Name: pipeline_hazard_controller

Overview:
Central stall/flush sequencer for the 5-stage RISC-V pipeline. It drives the stall (enable-hold) and flush (clear-to-bubble) controls of the F, D, E, M and W pipeline registers, including the control-signal registers. It detects load-use hazards and taken branches. It also owns a registered request/ready handshake to data memory, with a wait-timeout watchdog and a saturating stall-cycle counter.

Parameters:
TIMEOUT, 64, max cycles in MEM_WAIT before entering ERROR (range 1..255).
CNT_W, 16, width of stall-cycle performance counter.

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous reset, active-low (asserted when 0)
rs1_d  input  5  source register 1 of instruction in D
rs2_d  input  5  source register 2 of instruction in D
rd_e  input  5  destination register of instruction in E
load_e  input  1  instruction in E is a load (ResultSrc = memory)
pc_src_e  input  1  branch/jump taken, resolved in E
mem_access_m  input  1  instruction in M is a load or store
mem_ready  input  1  data memory completes current access this cycle
mem_req  output  1  data memory request
stall_f  output  1  hold PC/F register
stall_d  output  1  hold F/D register
stall_e  output  1  hold D/E register
stall_m  output  1  hold E/M register
flush_d  output  1  clear F/D register
flush_e  output  1  clear D/E register
flush_w  output  1  clear M/W register (bubble into W)
mem_err  output  1  sticky memory-timeout error
stall_cnt  output  CNT_W  cycles with stall_f=1, saturating

Behaviour:
- States: RUN, MEM_WAIT, ERROR. Reset: state=RUN, wait counter=0, mem_err=0, stall_cnt=0.
- While reset=0, all combinational outputs are forced to 0.
- mem_req = mem_access_m in RUN; 1 in MEM_WAIT; 0 in ERROR.
- mem_stall = (mem_req & ~mem_ready) | (state==ERROR).
- lw_stall = load_e & (rd_e != 0) & ((rd_e == rs1_d) | (rd_e == rs2_d)).
- Priority: mem_stall over lw_stall over pc_src_e.
- If mem_stall: stall_f = stall_d = stall_e = stall_m = 1, flush_w = 1, flush_d = flush_e = 0. E must keep the branch/load it holds, so no flush occurs during a memory stall.
- Else if lw_stall: stall_f = stall_d = 1, flush_e = 1. If pc_src_e is also 1, flush_d = 1 as well. Others 0.
- Else if pc_src_e: flush_d = flush_e = 1, no stalls.
- Else: all stall/flush outputs 0.
- Transitions:
  - RUN: if mem_access_m & ~mem_ready, go to MEM_WAIT next cycle and set wait counter to 1. If mem_ready is 1 in the same cycle, the access completes with zero stall and the state stays RUN.
  - MEM_WAIT: if mem_ready, go to RUN next cycle. The pipeline advances in the mem_ready cycle because stalls drop combinationally. Otherwise the wait counter increments. When the counter equals TIMEOUT and mem_ready=0, go to ERROR.
  - ERROR: mem_err=1, full stall, mem_req=0. The only exit is reset.
- stall_cnt increments on each clock with stall_f=1 and holds at all-ones.
- Wait counter width is 8 bits. It clears on leaving MEM_WAIT.
- Reset asserted mid-MEM_WAIT or in ERROR returns the block to RUN immediately (asynchronous). mem_req drops the same instant.
- No registered outputs other than mem_err and stall_cnt. Latency from hazard input to stall/flush output is 0 cycles.

Test Plan:
- Load-use: load_e=1, rd_e=5, rs2_d=5, no memory access -> stall_f=stall_d=flush_e=1 for exactly one cycle; stall_cnt becomes 1. Same with rd_e=0 -> no stall.
- Branch: pc_src_e=1 alone -> flush_d=flush_e=1, stalls 0. Branch together with load-use -> stall_f=stall_d=flush_d=flush_e=1.
- Memory wait: mem_access_m=1, mem_ready held 0 for 3 cycles then 1 -> mem_req=1 for 4 cycles; stall_f/d/e/m and flush_w=1 for 3 cycles; then RUN; stall_cnt=3.
- Zero-wait access: mem_access_m=1 and mem_ready=1 in the same cycle -> mem_req=1, no stall, state stays RUN.
- Timeout with TIMEOUT=4: mem_ready never asserted -> ERROR entered after 4 MEM_WAIT cycles; mem_err=1; mem_req=0; all stalls held 1 indefinitely. Asserting reset=0 clears mem_err and stall_cnt and returns to RUN.
- Priority and reset: pc_src_e=1 during a memory stall -> flush_d=flush_e=0 until mem_ready, then flush_d=flush_e=1. Asserting reset mid-MEM_WAIT -> mem_req=0 immediately and stall_cnt=0.
